// File: rtl/commit_scheduler.sv
// In-order commit sequencer: allocates ROB tags at issue, collects writebacks,
// retires one entry per cycle, answers two tag searches and sequences mispredict flush.
module commit_scheduler #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 rob_full,
  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]          wb_val,
  input  logic                 wb_mispredict,
  input  logic [31:0]          wb_target,
  input  logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic                 search_ready_1,
  output logic [31:0]          search_val_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic                 search_ready_2,
  output logic [31:0]          search_val_2,
  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = {1'b1, {ROB_WIDTH{1'b0}}};

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ROB_WIDTH-1:0]      r_head, r_tail;
  logic [ROB_WIDTH:0]        r_count;
  logic [DEPTH-1:0]          r_busy, r_done, r_mis;
  logic [DEPTH-1:0][4:0]     r_rd;
  logic [DEPTH-1:0][31:0]    r_val, r_target;
  logic [31:0]               r_clear_pc;

  logic                      w_run, w_full, w_alloc, w_wb, w_commit;
  logic [1:0][ROB_WIDTH-1:0] w_sid;
  logic [1:0]                w_srdy;
  logic [1:0][31:0]          w_sval;

  assign w_run    = (r_state == S_RUN);
  assign w_full   = (r_count == FULL_CNT);
  assign w_alloc  = w_run && issue_valid && !w_full;
  assign w_wb     = w_run && wb_valid && r_busy[wb_rob_id];
  assign w_commit = rdy_in && w_run && r_busy[r_head] && r_done[r_head];

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (!rst_in)     r_state <= S_RUN;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_commit && r_mis[r_head]) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue_rob_id  = r_tail;
    rob_full      = !w_run || w_full;
    commit_ready  = w_commit;
    commit_reg_id = r_rd[r_head];
    commit_val    = r_val[r_head];
    commit_rob_id = r_head;
    clear         = !w_run;
    clear_pc      = w_run ? 32'd0 : r_clear_pc;
  end

  // Window state. Order inside the RUN branch matters: commit frees the head
  // before alloc claims the tail, so a wrapped tail==head slot ends up busy.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_done     <= '0;
      r_mis      <= '0;
      r_rd       <= '0;
      r_val      <= '0;
      r_target   <= '0;
      r_clear_pc <= '0;
    end else if (rdy_in) begin
      if (!w_run) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_busy  <= '0;
        r_done  <= '0;
      end else begin
        if (w_wb) begin
          r_done[wb_rob_id]   <= 1'b1;
          r_val[wb_rob_id]    <= wb_val;
          r_mis[wb_rob_id]    <= wb_mispredict;
          r_target[wb_rob_id] <= wb_target;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
          if (r_mis[r_head]) r_clear_pc <= r_target[r_head];
        end
        if (w_alloc) begin
          r_busy[r_tail] <= 1'b1;
          r_done[r_tail] <= 1'b0;
          r_mis[r_tail]  <= 1'b0;
          r_rd[r_tail]   <= issue_rd;
          r_tail         <= r_tail + 1'b1;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Search: stored value first, then same-cycle writeback bypass; blind during flush.
  assign w_sid = {search_rob_id_2, search_rob_id_1};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_srdy[p] = 1'b0;
      w_sval[p] = '0;
      if (w_run) begin
        if (r_busy[w_sid[p]] && r_done[w_sid[p]]) begin
          w_srdy[p] = 1'b1;
          w_sval[p] = r_val[w_sid[p]];
        end else if (wb_valid && (wb_rob_id == w_sid[p])) begin
          w_srdy[p] = 1'b1;
          w_sval[p] = wb_val;
        end
      end
    end
  end

  assign search_ready_1 = w_srdy[0];
  assign search_val_1   = w_sval[0];
  assign search_ready_2 = w_srdy[1];
  assign search_val_2   = w_sval[1];

endmodule
